// File: rtl/vc_input_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vc_input_buffer_pkg
//
// Shared NoC types and constants for the router input buffer:
//   - VC_NUM / VC_SIZE : number of virtual channels and VC index width
//   - BUFFER_SIZE      : entries per VC queue (power of two)
//   - flit_t           : flit with label, head routing data and payload
//   - credit_t         : credit returned upstream (valid + VC)
//   - pkt_state_t      : per-VC packet framing state
// ---------------------------------------------------------------------------
package vc_input_buffer_pkg;

    localparam int VC_NUM       = 2;
    localparam int VC_SIZE      = $clog2(VC_NUM);
    localparam int BUFFER_SIZE  = 8;
    localparam int DEST_SIZE    = 4;
    localparam int PAYLOAD_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD = 2'b00,
        BODY = 2'b01,
        TAIL = 2'b10
    } flit_label_t;

    typedef struct packed {
        logic [VC_SIZE-1:0]   vc_id;
        logic [DEST_SIZE-1:0] dest;
    } head_data_t;

    typedef struct packed {
        flit_label_t             flit_label;
        head_data_t              head_data;
        logic [PAYLOAD_SIZE-1:0] payload;
    } flit_t;

    typedef struct packed {
        logic               valid;
        logic [VC_SIZE-1:0] vc;
    } credit_t;

    typedef enum logic {
        IDLE      = 1'b0,
        IN_PACKET = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/vc_input_buffer_circular_buffer.sv
// ---------------------------------------------------------------------------
// vc_input_buffer_circular_buffer
//
// Single-queue first-word-fall-through FIFO of flit_t, DEPTH entries.
//   clk, rst      : clock, synchronous active-high reset
//   data_i        : flit to enqueue
//   write_i       : enqueue request
//   read_i        : dequeue request
//   data_o        : front flit (zero while empty)
//   is_empty_o    : no entries stored
//   is_full_o     : DEPTH entries stored
//   overflow_o    : write request rejected this cycle (queue full, no pop)
//   underflow_o   : read request on an empty queue this cycle
// A write to a full queue is still accepted when a pop happens in the same
// cycle, since the pop frees the slot. A read on an empty queue is ignored
// even if a write arrives in the same cycle.
// ---------------------------------------------------------------------------
module vc_input_buffer_circular_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  write_i,
    input  logic  read_i,
    output flit_t data_o,
    output logic  is_empty_o,
    output logic  is_full_o,
    output logic  overflow_o,
    output logic  underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    flit_t             mem_q [DEPTH];
    flit_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_read;
    logic              do_write;

    assign is_empty_o  = (count_q == '0);
    assign is_full_o   = (count_q == CNT_W'(DEPTH));
    assign do_read     = read_i && !is_empty_o;
    assign do_write    = write_i && (!is_full_o || do_read);
    assign overflow_o  = write_i && !do_write;
    assign underflow_o = read_i && is_empty_o;

    // Stale storage is masked so the front of an empty queue reads as zero.
    assign data_o = is_empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable while non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// ---------------------------------------------------------------------------
// vc_input_buffer
//
// Router input-port storage: VC_NUM independent FWFT queues of BUFFER_SIZE
// flits, one credit returned upstream per flit consumed.
//   clk, rst        : clock, synchronous active-high reset
//   data_i          : incoming flit
//   valid_flit_i    : data_i valid this cycle
//   vc_i            : target VC of data_i
//   read_i          : pop the front flit of read_vc_i
//   read_vc_i       : VC to pop
//   data_o          : front flit of every VC (packed, zero when empty)
//   is_empty_o      : per-VC empty
//   is_full_o       : per-VC full
//   credit_valid_o  : credit returned upstream (one cycle after a pop)
//   credit_vc_o     : VC of the returned credit, holds its last value
//   error_o         : sticky overflow / underflow / protocol error
//
// Optional feature macro: VC_INPUT_BUFFER_PROTOCOL_CHECK_EN
//   When defined, a per-VC HEAD/BODY/TAIL framing checker runs on accepted
//   writes and flags malformed packets or HEADs carrying the wrong vc_id.
// ---------------------------------------------------------------------------
module vc_input_buffer #(
    parameter int VC_NUM      = vc_input_buffer_pkg::VC_NUM,
    parameter int BUFFER_SIZE = vc_input_buffer_pkg::BUFFER_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  vc_input_buffer_pkg::flit_t               data_i,
    input  logic                                     valid_flit_i,
    input  logic [$clog2(VC_NUM)-1:0]                vc_i,
    input  logic                                     read_i,
    input  logic [$clog2(VC_NUM)-1:0]                read_vc_i,
    output vc_input_buffer_pkg::flit_t [VC_NUM-1:0]  data_o,
    output logic [VC_NUM-1:0]                        is_empty_o,
    output logic [VC_NUM-1:0]                        is_full_o,
    output logic                                     credit_valid_o,
    output logic [$clog2(VC_NUM)-1:0]                credit_vc_o,
    output logic                                     error_o
);

    import vc_input_buffer_pkg::credit_t;
`ifdef VC_INPUT_BUFFER_PROTOCOL_CHECK_EN
    import vc_input_buffer_pkg::pkt_state_t;
    import vc_input_buffer_pkg::IDLE;
    import vc_input_buffer_pkg::IN_PACKET;
    import vc_input_buffer_pkg::HEAD;
    import vc_input_buffer_pkg::BODY;
    import vc_input_buffer_pkg::TAIL;
`endif

    localparam int VC_W = $clog2(VC_NUM);

    logic [VC_NUM-1:0] write_vc;
    logic [VC_NUM-1:0] read_vc;
    logic [VC_NUM-1:0] overflow;
    logic [VC_NUM-1:0] underflow;
    logic              read_ok;
    logic              proto_err;
    credit_t           credit_q, credit_d;
    logic              error_q, error_d;

    // Demultiplex the single write and read request onto per-VC strobes.
    always_comb begin
        write_vc = '0;
        read_vc  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            write_vc[v] = valid_flit_i && (vc_i == VC_W'(v));
            read_vc[v]  = read_i && (read_vc_i == VC_W'(v));
        end
    end

    for (genvar gv = 0; gv < VC_NUM; gv++) begin : g_vc
        vc_input_buffer_circular_buffer #(
            .DEPTH (BUFFER_SIZE)
        ) u_queue (
            .clk         (clk),
            .rst         (rst),
            .data_i      (data_i),
            .write_i     (write_vc[gv]),
            .read_i      (read_vc[gv]),
            .data_o      (data_o[gv]),
            .is_empty_o  (is_empty_o[gv]),
            .is_full_o   (is_full_o[gv]),
            .overflow_o  (overflow[gv]),
            .underflow_o (underflow[gv])
        );
    end

    assign read_ok = read_i && !is_empty_o[read_vc_i];

`ifdef VC_INPUT_BUFFER_PROTOCOL_CHECK_EN
    pkt_state_t [VC_NUM-1:0] pkt_state_q, pkt_state_d;

    // Framing is tracked only for flits that were actually stored; a dropped
    // flit is already reported as an overflow.
    always_comb begin
        pkt_state_d = pkt_state_q;
        proto_err   = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (write_vc[v] && !overflow[v]) begin
                case (data_i.flit_label)
                    HEAD: begin
                        if (pkt_state_q[v] == IN_PACKET) begin
                            proto_err = 1'b1;
                        end else begin
                            pkt_state_d[v] = IN_PACKET;
                        end
                        if (data_i.head_data.vc_id != vc_i) begin
                            proto_err = 1'b1;
                        end
                    end
                    BODY: begin
                        if (pkt_state_q[v] == IDLE) begin
                            proto_err = 1'b1;
                        end
                    end
                    TAIL: begin
                        if (pkt_state_q[v] == IDLE) begin
                            proto_err = 1'b1;
                        end else begin
                            pkt_state_d[v] = IDLE;
                        end
                    end
                    default: begin
                        proto_err = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_state_q <= {VC_NUM{IDLE}};
        end else begin
            pkt_state_q <= pkt_state_d;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

    // The credit VC holds its last value between pops.
    always_comb begin
        credit_d.valid = read_ok;
        credit_d.vc    = read_ok ? read_vc_i : credit_q.vc;
        error_d        = error_q | (|overflow) | (|underflow) | proto_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
            error_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            error_q  <= error_d;
        end
    end

    assign credit_valid_o = credit_q.valid;
    assign credit_vc_o    = credit_q.vc;
    assign error_o        = error_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_input_buffer
//
// Directed self-checking bench for vc_input_buffer with default parameters
// (2 VCs, 8 entries each). Inputs change on the falling edge and outputs are
// sampled on the falling edge after the rising edge that consumed them.
// The framing-checker steps run only when
// VC_INPUT_BUFFER_PROTOCOL_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_vc_input_buffer;
    import vc_input_buffer_pkg::*;

    logic              clk;
    logic              rst;
    flit_t             data_i;
    logic              valid_flit_i;
    logic [0:0]        vc_i;
    logic              read_i;
    logic [0:0]        read_vc_i;
    flit_t [1:0]       data_o;
    logic [1:0]        is_empty_o;
    logic [1:0]        is_full_o;
    logic              credit_valid_o;
    logic [0:0]        credit_vc_o;
    logic              error_o;

    int checks;
    int passes;
    int fails;
    int credit_count;
    int credit_bad;
    flit_t f;
    flit_t expect_flit;
    flit_label_t lbl;

    vc_input_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .valid_flit_i   (valid_flit_i),
        .vc_i           (vc_i),
        .read_i         (read_i),
        .read_vc_i      (read_vc_i),
        .data_o         (data_o),
        .is_empty_o     (is_empty_o),
        .is_full_o      (is_full_o),
        .credit_valid_o (credit_valid_o),
        .credit_vc_o    (credit_vc_o),
        .error_o        (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(input flit_label_t l, input logic vcid, input logic [15:0] p);
        flit_t r;
        r.flit_label        = l;
        r.head_data.vc_id   = vcid;
        r.head_data.dest    = 4'h3;
        r.payload           = p;
        return r;
    endfunction

    // Drive one cycle of inputs, then return the request lines to idle.
    task automatic applyStimulus(input logic v, input logic vc, input flit_t fl,
                                 input logic r, input logic rvc);
        valid_flit_i = v;
        vc_i         = vc;
        data_i       = fl;
        read_i       = r;
        read_vc_i    = rvc;
        @(negedge clk);
        valid_flit_i = 1'b0;
        read_i       = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        rst = 1'b1; valid_flit_i = 1'b0; vc_i = '0; data_i = '0;
        read_i = 1'b0; read_vc_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_empty", 32'(is_empty_o), 32'h3);
        checkOutput("rst_full", 32'(is_full_o), 32'h0);
        checkOutput("rst_credit_valid", 32'(credit_valid_o), 32'h0);
        checkOutput("rst_credit_vc", 32'(credit_vc_o), 32'h0);
        checkOutput("rst_error", 32'(error_o), 32'h0);
        checkOutput("rst_data0", 32'(data_o[0]), 32'h0);
        checkOutput("rst_data1", 32'(data_o[1]), 32'h0);

        $display("[TB] single HEAD to VC1");
        f = mk(HEAD, 1'b1, 16'hA001);
        applyStimulus(1'b1, 1'b1, f, 1'b0, 1'b0);
        checkOutput("w1_data1", 32'(data_o[1]), 32'(f));
        checkOutput("w1_empty", 32'(is_empty_o), 32'h1);
        checkOutput("w1_no_credit", 32'(credit_valid_o), 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("r1_credit_valid", 32'(credit_valid_o), 32'h1);
        checkOutput("r1_credit_vc", 32'(credit_vc_o), 32'h1);
        checkOutput("r1_empty", 32'(is_empty_o), 32'h3);
        checkOutput("r1_error", 32'(error_o), 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("idle_credit_valid", 32'(credit_valid_o), 32'h0);
        checkOutput("idle_credit_vc_hold", 32'(credit_vc_o), 32'h1);

        $display("[TB] fill VC0 and overflow");
        for (int i = 0; i < 8; i++) begin
            if (i == 0) lbl = HEAD; else lbl = BODY;
            applyStimulus(1'b1, 1'b0, mk(lbl, 1'b0, 16'(16'h0100 + i)), 1'b0, 1'b0);
            if (i == 6) checkOutput("fill7_not_full", 32'(is_full_o), 32'h0);
        end
        checkOutput("fill8_full", 32'(is_full_o), 32'h1);
        checkOutput("fill8_error", 32'(error_o), 32'h0);
        applyStimulus(1'b1, 1'b0, mk(BODY, 1'b0, 16'h01FF), 1'b0, 1'b0);
        checkOutput("ovf_error", 32'(error_o), 32'h1);
        checkOutput("ovf_full", 32'(is_full_o), 32'h1);
        checkOutput("ovf_front", 32'(data_o[0]), 32'(mk(HEAD, 1'b0, 16'h0100)));
        for (int i = 0; i < 8; i++) begin
            if (i == 0) lbl = HEAD; else lbl = BODY;
            checkOutput("drain1_data", 32'(data_o[0]), 32'(mk(lbl, 1'b0, 16'(16'h0100 + i))));
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checkOutput("drain1_credit", 32'(credit_valid_o), 32'h1);
        end
        checkOutput("drain1_empty", 32'(is_empty_o), 32'h3);
        doReset();
        checkOutput("rst2_error", 32'(error_o), 32'h0);

        $display("[TB] simultaneous read/write on full VC0");
        for (int i = 0; i < 8; i++) begin
            if (i == 0) lbl = HEAD; else lbl = BODY;
            applyStimulus(1'b1, 1'b0, mk(lbl, 1'b0, 16'(16'h0300 + i)), 1'b0, 1'b0);
        end
        checkOutput("refill_full", 32'(is_full_o), 32'h1);
        applyStimulus(1'b1, 1'b0, mk(BODY, 1'b0, 16'h03AA), 1'b1, 1'b0);
        checkOutput("rw_full", 32'(is_full_o), 32'h1);
        checkOutput("rw_credit_valid", 32'(credit_valid_o), 32'h1);
        checkOutput("rw_credit_vc", 32'(credit_vc_o), 32'h0);
        checkOutput("rw_error", 32'(error_o), 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) expect_flit = mk(BODY, 1'b0, 16'(16'h0301 + i));
            else       expect_flit = mk(BODY, 1'b0, 16'h03AA);
            checkOutput("drain2_data", 32'(data_o[0]), 32'(expect_flit));
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("drain2_empty", 32'(is_empty_o), 32'h3);
        checkOutput("drain2_error", 32'(error_o), 32'h0);

        $display("[TB] 20 alternating write/read on VC1");
        credit_count = 0;
        credit_bad   = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) lbl = HEAD; else if (i == 19) lbl = TAIL; else lbl = BODY;
            f = mk(lbl, 1'b1, 16'(16'h1000 + i));
            applyStimulus(1'b1, 1'b1, f, 1'b0, 1'b0);
            if (credit_valid_o) credit_count++;
            checkOutput("alt_data", 32'(data_o[1]), 32'(f));
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (credit_valid_o) begin
                credit_count++;
                if (credit_vc_o != 1'b1) credit_bad++;
            end
        end
        checkOutput("alt_credit_count", 32'(credit_count), 32'd20);
        checkOutput("alt_credit_vc", 32'(credit_bad), 32'd0);
        checkOutput("alt_empty", 32'(is_empty_o), 32'h3);
        checkOutput("alt_error", 32'(error_o), 32'h0);

        $display("[TB] read on empty VC0");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("udf_no_credit", 32'(credit_valid_o), 32'h0);
        checkOutput("udf_error", 32'(error_o), 32'h1);
        doReset();
        checkOutput("rst3_error", 32'(error_o), 32'h0);
        checkOutput("rst3_empty", 32'(is_empty_o), 32'h3);

        $display("[TB] write and read same empty VC1");
        f = mk(HEAD, 1'b1, 16'h2222);
        applyStimulus(1'b1, 1'b1, f, 1'b1, 1'b1);
        checkOutput("wre_empty", 32'(is_empty_o), 32'h1);
        checkOutput("wre_data1", 32'(data_o[1]), 32'(f));
        checkOutput("wre_no_credit", 32'(credit_valid_o), 32'h0);
        checkOutput("wre_error", 32'(error_o), 32'h1);
        doReset();

        $display("[TB] write VC0 while reading VC1");
        applyStimulus(1'b1, 1'b1, mk(HEAD, 1'b1, 16'h3333), 1'b0, 1'b0);
        f = mk(HEAD, 1'b0, 16'h4444);
        applyStimulus(1'b1, 1'b0, f, 1'b1, 1'b1);
        checkOutput("xvc_empty", 32'(is_empty_o), 32'h2);
        checkOutput("xvc_data0", 32'(data_o[0]), 32'(f));
        checkOutput("xvc_credit_valid", 32'(credit_valid_o), 32'h1);
        checkOutput("xvc_credit_vc", 32'(credit_vc_o), 32'h1);
        checkOutput("xvc_error", 32'(error_o), 32'h0);

`ifdef VC_INPUT_BUFFER_PROTOCOL_CHECK_EN
        $display("[TB] packet framing checker");
        doReset();
        applyStimulus(1'b1, 1'b0, mk(BODY, 1'b0, 16'h5555), 1'b0, 1'b0);
        checkOutput("proto_body_idle", 32'(error_o), 32'h1);
        doReset();
        applyStimulus(1'b1, 1'b1, mk(HEAD, 1'b1, 16'h6001), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, mk(BODY, 1'b1, 16'h6002), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, mk(TAIL, 1'b1, 16'h6003), 1'b0, 1'b0);
        checkOutput("proto_legal_pkt", 32'(error_o), 32'h0);
        applyStimulus(1'b1, 1'b0, mk(HEAD, 1'b1, 16'h6004), 1'b0, 1'b0);
        checkOutput("proto_bad_vcid", 32'(error_o), 32'h1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
